// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the Y86 pipeline control unit: instruction codes,
// register/status encodings and the control FSM state type.
package pipe_ctrl_pkg;

    localparam int NIBBLE = 4;
    typedef logic [NIBBLE-1:0] nibble_t;

    // Instruction codes
    localparam nibble_t INOP    = 4'h1;
    localparam nibble_t IMRMOVL = 4'h5;
    localparam nibble_t IJXX    = 4'h7;
    localparam nibble_t IRET    = 4'h9;
    localparam nibble_t IPOPL   = 4'hB;

    // Register ids
    localparam nibble_t REAX  = 4'h0;
    localparam nibble_t RESP  = 4'h4;
    localparam nibble_t RNONE = 4'hF;

    // Status codes
    localparam nibble_t SAOK = 4'h1;
    localparam nibble_t SADR = 4'h2;
    localparam nibble_t SINS = 4'h3;
    localparam nibble_t SHLT = 4'h4;

    // Control FSM encodings
    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_HALT = 1'b1
    } pc_state_t;

    // True for instructions whose destination value only appears after M
    function automatic logic is_load(input nibble_t icode);
        return (icode == IMRMOVL) || (icode == IPOPL);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs from the pipeline and stall/bubble controls back to it.
// master: pipeline side, slave: pipe_ctrl.
interface pipe_ctrl_if #(
    parameter int PERF_W = 32
);
    import pipe_ctrl_pkg::*;

    nibble_t            D_icode_i;
    nibble_t            d_srcA_i;
    nibble_t            d_srcB_i;
    nibble_t            E_icode_i;
    nibble_t            E_dstM_i;
    logic               e_Cnd_i;
    nibble_t            m_stat_i;
    nibble_t            W_stat_i;

    logic               F_stall_o;
    logic               D_stall_o;
    logic               D_bubble_o;
    logic               E_bubble_o;
    logic               M_bubble_o;
    logic               W_stall_o;
    logic               halted_o;
    nibble_t            stat_o;
    logic [PERF_W-1:0]  perf_cyc_o;
    logic [PERF_W-1:0]  perf_stall_o;
    logic [PERF_W-1:0]  perf_bubble_o;

    modport master (
        output D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, e_Cnd_i,
               m_stat_i, W_stat_i,
        input  F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o,
               W_stall_o, halted_o, stat_o, perf_cyc_o, perf_stall_o,
               perf_bubble_o
    );

    modport slave (
        input  D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, e_Cnd_i,
               m_stat_i, W_stat_i,
        output F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o,
               W_stall_o, halted_o, stat_o, perf_cyc_o, perf_stall_o,
               perf_bubble_o
    );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with enable; sticks at all-ones.
module pipe_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_reg;

    // Count enabled cycles, holding once every bit is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_reg <= '0;
        else if (en && !(&cnt_reg))
            cnt_reg <= cnt_reg + W'(1);
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage Y86 core: stall/bubble generation for
// load/use, ret, mispredicted jumps and exception halt.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RET_WAIT = 3,
    parameter int PERF_W   = 32
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   pif
);

    localparam int CNT_W = $clog2(RET_WAIT) + 1;
    localparam logic [CNT_W-1:0] RET_LOAD = CNT_W'(RET_WAIT - 1);

    pc_state_t        state_reg, state_next;
    logic [CNT_W-1:0] ret_cnt_reg, ret_cnt_next;
    nibble_t          stat_reg, stat_next;

    logic lu, mis, ret_d, rp, exc_m, exc_w;
    logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, halted;

    // Hazard terms that forwarding cannot resolve
    always_comb begin
        lu    = is_load(pif.E_icode_i) && (pif.E_dstM_i != RNONE) &&
                ((pif.E_dstM_i == pif.d_srcA_i) || (pif.E_dstM_i == pif.d_srcB_i));
        mis   = (pif.E_icode_i == IJXX) && !pif.e_Cnd_i;
        ret_d = (pif.D_icode_i == IRET);
        rp    = ret_d || (ret_cnt_reg != '0);
        exc_m = (pif.m_stat_i != SAOK);
        exc_w = (pif.W_stat_i != SAOK);
    end

    // State, ret counter and latched status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= PC_RUN;
            ret_cnt_reg <= '0;
            stat_reg    <= SAOK;
        end else begin
            state_reg   <= state_next;
            ret_cnt_reg <= ret_cnt_next;
            stat_reg    <= stat_next;
        end
    end

    // Next state and pipeline controls; reset forces a flush pattern
    always_comb begin
        state_next   = state_reg;
        ret_cnt_next = ret_cnt_reg;
        stat_next    = stat_reg;
        f_stall      = 1'b0;
        d_stall      = 1'b0;
        d_bubble     = 1'b0;
        e_bubble     = 1'b0;
        m_bubble     = 1'b0;
        w_stall      = 1'b0;
        halted       = 1'b0;
        if (rst) begin
            d_bubble = 1'b1;
            e_bubble = 1'b1;
            m_bubble = 1'b1;
        end else begin
            case (state_reg)
                PC_RUN: begin
                    f_stall  = lu || rp;
                    d_stall  = lu;
                    d_bubble = mis || (rp && !lu);
                    e_bubble = mis || lu;
                    m_bubble = exc_m || exc_w;
                    w_stall  = exc_w;
                    // A ret squashed by a mispredict or held by load/use does not start the wait
                    if (ret_d && !lu && !mis && ret_cnt_reg == '0)
                        ret_cnt_next = RET_LOAD;
                    else if (ret_cnt_reg != '0)
                        ret_cnt_next = ret_cnt_reg - CNT_W'(1);
                    if (exc_w) begin
                        state_next = PC_HALT;
                        stat_next  = pif.W_stat_i;
                    end
                end
                default: begin
                    f_stall  = 1'b1;
                    d_stall  = 1'b1;
                    e_bubble = 1'b1;
                    m_bubble = 1'b1;
                    w_stall  = 1'b1;
                    halted   = 1'b1;
                end
            endcase
        end
    end

    assign pif.F_stall_o  = f_stall;
    assign pif.D_stall_o  = d_stall;
    assign pif.D_bubble_o = d_bubble;
    assign pif.E_bubble_o = e_bubble;
    assign pif.M_bubble_o = m_bubble;
    assign pif.W_stall_o  = w_stall;
    assign pif.halted_o   = halted;
    assign pif.stat_o     = stat_reg;

`ifdef PIPE_CTRL_PERF_EN
    logic [2:0]        perf_en;
    logic [PERF_W-1:0] perf_val [3];

    // Counters run only while the core is not halted
    always_comb begin
        perf_en[0] = (state_reg == PC_RUN);
        perf_en[1] = (state_reg == PC_RUN) && f_stall;
        perf_en[2] = (state_reg == PC_RUN) && (d_bubble || e_bubble);
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        pipe_perf_cnt #(.W(PERF_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .en  (perf_en[gi]),
            .cnt (perf_val[gi])
        );
    end

    assign pif.perf_cyc_o    = perf_val[0];
    assign pif.perf_stall_o  = perf_val[1];
    assign pif.perf_bubble_o = perf_val[2];
`else
    assign pif.perf_cyc_o    = '0;
    assign pif.perf_stall_o  = '0;
    assign pif.perf_bubble_o = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the five-stage Y86 core: generates stall/bubble controls for the F, D, E, M and W pipeline registers.
- Covers load/use hazards, ret processing, mispredicted jumps and exception halt.
- Sits beside the forwarding selectors. It handles the hazards forwarding cannot resolve: a load/use value not yet read from memory, and a return address not known until W.
- Holds sequential ret-wait state and a halt state machine; the core freezes on an exception until reset.

Parameters:
- RET_WAIT, 3: cycles F is held after a ret enters D, including that D cycle; must be ≥1. Counter width is clog2(RET_WAIT)+1.
- PERF_W, 32: width of the optional performance counters.

Ports:
- clk input 1: core clock, rising edge.
- rst input 1: asynchronous, active-high reset.
- D_icode_i input `NIBBLE: icode in D register.
- d_srcA_i input `NIBBLE: decode srcA.
- d_srcB_i input `NIBBLE: decode srcB.
- E_icode_i input `NIBBLE: icode in E register.
- E_dstM_i input `NIBBLE: dstM in E register.
- e_Cnd_i input 1: condition result from execute.
- m_stat_i input `NIBBLE: status out of memory stage.
- W_stat_i input `NIBBLE: status in W register.
- F_stall_o output 1: hold F register (PC).
- D_stall_o output 1: hold D register.
- D_bubble_o output 1: load nop into D.
- E_bubble_o output 1: load nop into E.
- M_bubble_o output 1: load nop into M.
- W_stall_o output 1: hold W register.
- halted_o output 1: core halted.
- stat_o output `NIBBLE: architectural status, latched at halt.
- perf_cyc_o output PERF_W: cycles since reset (optional feature).
- perf_stall_o output PERF_W: cycles with F_stall_o=1 (optional feature).
- perf_bubble_o output PERF_W: cycles with D_bubble_o or E_bubble_o (optional feature).

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high; clock port clk, reset port rst.
- Reset state: state=RUN, ret_cnt=0, stat_o=`SAOK, halted_o=0, perf counters 0.
- While rst=1: D_bubble_o=E_bubble_o=M_bubble_o=1 and all other controls 0, which flushes the pipe.
- Internal terms (combinational):
  - lu = (E_icode_i==`IMRMOVL || E_icode_i==`IPOPL) && E_dstM_i!=`RNONE && (E_dstM_i==d_srcA_i || E_dstM_i==d_srcB_i).
  - mis = E_icode_i==`IJXX && !e_Cnd_i.
  - retD = D_icode_i==`IRET.
  - rp = retD || ret_cnt!=0.
  - exc_m = m_stat_i!=`SAOK.
  - exc_w = W_stat_i!=`SAOK.
- RUN outputs:
  - F_stall=lu||rp.
  - D_stall=lu.
  - D_bubble=mis||(rp&&!lu).
  - E_bubble=mis||lu.
  - M_bubble=exc_m||exc_w.
  - W_stall=exc_w.
  - lu and D_bubble never both 1; D_stall has priority over D_bubble.
- ret_cnt update:
  - Loads RET_WAIT-1 when retD && !lu && !mis && ret_cnt==0.
  - Otherwise decrements while nonzero; it never wraps below 0.
  - A ret in D behind a mispredicted jump is squashed and does not load.
  - With RET_WAIT=1 the counter never loads.
- FSM RUN→HALTED on the edge where exc_w=1; stat_o latches W_stat_i on that edge.
- HALTED state:
  - F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0.
  - halted_o=1 and ret_cnt frozen.
  - Exits only through rst.
- Simultaneous events:
  - exc_w with lu/mis: RUN equations still apply that cycle; HALTED takes effect next cycle.
  - Reset mid-ret clears ret_cnt immediately.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: three saturating PERF_W counters count while !halted_o (perf_cyc counts every RUN cycle); they hold at all-ones and reset to 0.
- Undefined: no counter flops; perf_* outputs are tied to 0.

Decomposition:
- Add to defines.v, with the existing `IRET, `IJXX, `IMRMOVL, `IPOPL, `RNONE, `SAOK constants: the FSM encodings `PC_RUN=1'b0 and `PC_HALT=1'b1.
- One sub-module, pipe_perf_cnt: a saturating counter with enable, instantiated three times under the macro.

Test Plan:
- mrmovl to %eax in E (E_icode=5, E_dstM=0), D reads srcA=0 → F_stall=D_stall=E_bubble=1, D_bubble=0 for exactly 1 cycle.
- ret in D, RET_WAIT=3 → F_stall=1 and D_bubble=1 for 3 consecutive cycles, then 0; ret_cnt sequence 2,1,0.
- jXX in E with e_Cnd=0 and ret in D → D_bubble=E_bubble=1 for one cycle; ret_cnt stays 0; F_stall=1 only for that cycle.
- Load/use with ret in D (popl to %esp in E, ret reads %esp) → cycle 1 stall only, D_bubble=0; ret then gives 3 bubble cycles starting the next cycle.
- m_stat=`SADR for one cycle, then W_stat=`SADR → M_bubble=1 both cycles; next cycle halted_o=1, stat_o=`SADR, all stall outputs 1; rst pulse returns stat_o=`SAOK.
- With PIPE_CTRL_PERF_EN and PERF_W=4: after 20 run cycles perf_cyc_o=15 (saturated); after a halt the counters stop incrementing.
